// File: rtl/bus_arb_pkg.sv
// Shared types and bus field widths for the two-host bus arbiter.
// Optional watchdog is enabled with BUS_ARBITER_TIMEOUT_EN.
package bus_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   localparam logic [DATA_W-1:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_arb_timeout.sv
// Grant watchdog: counts granted cycles and flags expiry.
// Only instantiated when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_W      = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] r_count;

   // count granted cycles, restart whenever the arbiter is idle
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (run) begin
         r_count <= r_count + TIMEOUT_W'(1);
      end
   end

   assign expired = run & (r_count == LAST_CNT);

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 bus arbiter with per-transaction lock.
// Define BUS_ARBITER_TIMEOUT_EN to add forced completion on a hung device.
module bus_arbiter_2to1
   import bus_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_W      = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0][ADDR_W-1:0] host_address,
   input  logic [1:0][DATA_W-1:0] host_data_write,
   input  logic [1:0][MASK_W-1:0] host_write_mask,
   input  logic [1:0]             host_wen,
   input  logic [1:0]             host_ren,
   output logic [1:0][DATA_W-1:0] host_data_read,
   output logic [1:0]             host_ready,
   output logic [ADDR_W-1:0]      device_address,
   output logic [DATA_W-1:0]      device_data_write,
   output logic [MASK_W-1:0]      device_write_mask,
   output logic                   device_wen,
   output logic                   device_ren,
   input  logic [DATA_W-1:0]      device_data_read,
   input  logic                   device_ready,
   output logic [1:0]             grant_id,
   output logic                   timeout_flag
);

   localparam bit CFG_OK = (2 ** TIMEOUT_W) > TIMEOUT_CYCLES;

   arb_state_t r_state;
   arb_state_t w_next_state;
   logic       r_last;
   logic       w_next_last;
   logic [1:0] w_req;
   logic       w_sel;
   logic       w_expired;

   assign w_req = host_wen | host_ren;

`ifdef BUS_ARBITER_TIMEOUT_EN
   logic w_tmo;

   bus_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_W      (TIMEOUT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state == IDLE),
      .run     (r_state != IDLE),
      .expired (w_tmo)
   );

   assign w_expired = w_tmo & CFG_OK;
`else
   assign w_expired = 1'b0 & CFG_OK;
`endif

   // state and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_last  <= w_next_last;
      end
   end

   // arbitration, device mux and response routing
   always_comb begin
      w_next_state      = r_state;
      w_next_last       = r_last;
      w_sel             = 1'b0;
      device_address    = '0;
      device_data_write = '0;
      device_write_mask = '0;
      device_wen        = 1'b0;
      device_ren        = 1'b0;
      host_data_read    = '0;
      host_ready        = '0;
      grant_id          = '0;
      timeout_flag      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_req == 2'b11) begin
               w_next_state = r_last ? GNT0 : GNT1;
            end else if (w_req[0]) begin
               w_next_state = GNT0;
            end else if (w_req[1]) begin
               w_next_state = GNT1;
            end
         end
         GNT0, GNT1: begin
            w_sel             = (r_state == GNT1);
            grant_id[w_sel]   = 1'b1;
            device_address    = host_address[w_sel];
            device_data_write = host_data_write[w_sel];
            device_write_mask = host_write_mask[w_sel];
            device_wen        = host_wen[w_sel];
            device_ren        = host_ren[w_sel];
            host_data_read[w_sel] = device_data_read;
            host_ready[w_sel]     = device_ready;
            if (device_ready) begin
               w_next_state = IDLE;
               w_next_last  = w_sel;
            end else if (w_expired) begin
               device_address        = '0;
               device_data_write     = '0;
               device_write_mask     = '0;
               device_wen            = 1'b0;
               device_ren            = 1'b0;
               host_ready[w_sel]     = 1'b1;
               host_data_read[w_sel] = BUS_TIMEOUT_DATA;
               timeout_flag          = 1'b1;
               w_next_state          = IDLE;
               w_next_last           = w_sel;
            end else if (!w_req[w_sel]) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Randomized bench for bus_arbiter_2to1 against a transaction-level model.
// Timeout scenarios run only when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter_2to1;

   localparam int TOC = 8;
   localparam int TW  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0][31:0] h_addr;
   logic [1:0][31:0] h_wdat;
   logic [1:0][3:0]  h_mask;
   logic [1:0]       h_wen;
   logic [1:0]       h_ren;
   logic [1:0][31:0] h_rdat;
   logic [1:0]       h_rdy;
   logic [31:0]      d_addr;
   logic [31:0]      d_wdat;
   logic [3:0]       d_mask;
   logic             d_wen;
   logic             d_ren;
   logic [31:0]      d_rdat;
   logic             d_rdy;
   logic [1:0]       gnt;
   logic             tflag;

   int n_vec = 0;
   int n_err = 0;

   // model: owner of the device (-1 = nobody), most recently served host
   int   m_own   = -1;
   int   m_last  = 1;
   int   m_cnt   = 0;
   bit   m_valid = 1'b0;
   logic [1:0] m_done = '0;

   always #5 clk = ~clk;

   bus_arbiter_2to1 #(
      .TIMEOUT_CYCLES (TOC),
      .TIMEOUT_W      (TW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .host_address      (h_addr),
      .host_data_write   (h_wdat),
      .host_write_mask   (h_mask),
      .host_wen          (h_wen),
      .host_ren          (h_ren),
      .host_data_read    (h_rdat),
      .host_ready        (h_rdy),
      .device_address    (d_addr),
      .device_data_write (d_wdat),
      .device_write_mask (d_mask),
      .device_wen        (d_wen),
      .device_ren        (d_ren),
      .device_data_read  (d_rdat),
      .device_ready      (d_rdy),
      .grant_id          (gnt),
      .timeout_flag      (tflag)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_host(input int i, input bit w, input bit r,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
      h_wen[i]  = w;
      h_ren[i]  = r;
      h_addr[i] = a;
      h_wdat[i] = d;
      h_mask[i] = m;
   endtask

   task automatic new_req(input int i);
      bit w;
      w = 1'($urandom_range(0, 1));
      set_host(i, w, !w, $urandom, $urandom, 4'($urandom));
   endtask

   // one clock: check outputs at negedge, advance model at posedge
   task automatic step();
      logic [1:0]       e_gnt, e_hrdy, req;
      logic [1:0][31:0] e_hdat;
      logic [31:0]      e_addr, e_wdat;
      logic [3:0]       e_mask;
      logic             e_wen, e_ren, e_to;
      int o, n_own, n_last, n_cnt;
      @(negedge clk);
      e_gnt = '0; e_hrdy = '0; e_hdat = '0;
      e_addr = '0; e_wdat = '0; e_mask = '0;
      e_wen = 1'b0; e_ren = 1'b0; e_to = 1'b0;
      o = m_own;
      if (o >= 0) begin
         e_gnt[o]  = 1'b1;
         e_addr    = h_addr[o];
         e_wdat    = h_wdat[o];
         e_mask    = h_mask[o];
         e_wen     = h_wen[o];
         e_ren     = h_ren[o];
         e_hrdy[o] = d_rdy;
         e_hdat[o] = d_rdat;
`ifdef BUS_ARBITER_TIMEOUT_EN
         if (!d_rdy && m_cnt == TOC - 1) begin
            e_addr = '0; e_wdat = '0; e_mask = '0;
            e_wen = 1'b0; e_ren = 1'b0;
            e_hrdy[o] = 1'b1;
            e_hdat[o] = 32'hDEADBEEF;
            e_to = 1'b1;
         end
`endif
      end
      if (m_valid) begin
         chk("grant", 64'(gnt), 64'(e_gnt));
         chk("dev_addr", 64'(d_addr), 64'(e_addr));
         chk("dev_wdata", 64'(d_wdat), 64'(e_wdat));
         chk("dev_mask", 64'(d_mask), 64'(e_mask));
         chk("dev_wen", 64'(d_wen), 64'(e_wen));
         chk("dev_ren", 64'(d_ren), 64'(e_ren));
         chk("host_ready", 64'(h_rdy), 64'(e_hrdy));
         chk("host_rdata", 64'(h_rdat), 64'(e_hdat));
         chk("timeout", 64'(tflag), 64'(e_to));
      end
      req = h_wen | h_ren;
      n_own = m_own; n_last = m_last; n_cnt = m_cnt + 1;
      if (!rst) begin
         n_own = -1; n_last = 1; n_cnt = 0;
      end else if (o < 0) begin
         n_cnt = 0;
         if (req == 2'b11) n_own = 1 - m_last;
         else if (req[0]) n_own = 0;
         else if (req[1]) n_own = 1;
      end else if (e_hrdy[o]) begin
         n_own = -1; n_last = o;
      end else if (!req[o]) begin
         n_own = -1;
      end
      m_done = m_valid ? e_hrdy : 2'b00;
      @(posedge clk);
      m_own = n_own; m_last = n_last; m_cnt = n_cnt;
      m_valid = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      h_addr = '0; h_wdat = '0; h_mask = '0;
      h_wen = '0; h_ren = '0;
      d_rdat = '0; d_rdy = 1'b0;

      // reset with both hosts requesting, then contention with writes
      set_host(0, 1, 0, 32'h0, 32'hAAAA_0000, 4'b1111);
      set_host(1, 1, 0, 32'h4, 32'h0000_5555, 4'b0011);
      repeat (3) step();
      rst = 1'b1;
      d_rdy = 1'b1;
      d_rdat = 32'hCAFE_0001;
      repeat (9) step();

      // single read by host 1
      set_host(0, 0, 0, 0, 0, 0);
      set_host(1, 0, 0, 0, 0, 0);
      d_rdy = 1'b0;
      step();
      set_host(1, 0, 1, 32'h100, 0, 0);
      step();
      step();
      step();
      d_rdy = 1'b1;
      d_rdat = 32'h1234_5678;
      step();
      set_host(1, 0, 0, 0, 0, 0);
      d_rdy = 1'b0;
      step();

      // abort by host 0, then a tie
      set_host(0, 0, 1, 32'h200, 0, 0);
      step();
      step();
      set_host(0, 0, 0, 32'h200, 0, 0);
      step();
      step();
      set_host(0, 0, 1, 32'h300, 0, 0);
      set_host(1, 0, 1, 32'h304, 0, 0);
      step();
      d_rdy = 1'b1;
      d_rdat = 32'h0BAD_F00D;
      repeat (4) step();

      // reset while host 1 is granted
      d_rdy = 1'b0;
      for (int k = 0; k < 20 && m_own != 1; k++) begin
         d_rdy = 1'($urandom_range(0, 1));
         step();
      end
      chk("reach_gnt1", 64'(gnt), 64'd2);
      d_rdy = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      set_host(0, 0, 0, 0, 0, 0);
      set_host(1, 0, 0, 0, 0, 0);
      d_rdy = 1'b1;
      d_rdat = 32'h5A5A_5A5A;
      repeat (3) step();
      d_rdy = 1'b0;

`ifdef BUS_ARBITER_TIMEOUT_EN
      // hung device, then ready on the last permitted cycle
      set_host(0, 0, 1, 32'h400, 0, 0);
      repeat (12) step();
      set_host(0, 0, 0, 0, 0, 0);
      step();
      set_host(0, 0, 1, 32'h404, 0, 0);
      d_rdat = 32'h7777_8888;
      for (int k = 0; k < 20; k++) begin
         d_rdy = (m_own == 0 && m_cnt == TOC - 1);
         step();
      end
      set_host(0, 0, 0, 0, 0, 0);
      d_rdy = 1'b0;
      step();
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (m_done[i]) begin
               if ($urandom_range(0, 1) == 1) new_req(i);
               else set_host(i, 0, 0, 0, 0, 0);
            end else if (!(h_wen[i] | h_ren[i])) begin
               if ($urandom_range(0, 3) == 0) new_req(i);
            end else if (m_own == i && $urandom_range(0, 19) == 0) begin
               set_host(i, 0, 0, h_addr[i], h_wdat[i], h_mask[i]);
            end
         end
         rst = ($urandom_range(0, 199) != 0);
         d_rdy = ($urandom_range(0, 2) == 0);
         d_rdat = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
